// File: rtl/pulse_pattern_gen_pkg.sv
// Shared types and defaults for the pulse pattern generator.
package pulse_pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_NUM_SEG = 4;

  // Enable level for a segment: even segments drive on_level, odd ones its inverse.
  function automatic logic seg_level(input logic idx_odd, input logic on_level);
    return idx_odd ? ~on_level : on_level;
  endfunction

endpackage

// File: rtl/pulse_pattern_gen_if.sv
// Control/status bundle between the timing-config registers and the generator.
interface pulse_pattern_gen_if #(
  parameter int CNT_W     = 32,
  parameter int NUM_SEG   = 4,
  parameter int SEG_IDX_W = $clog2(NUM_SEG)
) ();

  logic                     start;
  logic                     stop;
  logic                     mode;
  logic [NUM_SEG*CNT_W-1:0] seg_len;
  logic                     en;
  logic                     busy;
  logic [SEG_IDX_W-1:0]     seg_idx;
  logic                     frame_done;

  modport master (
    output start, stop, mode, seg_len,
    input  en, busy, seg_idx, frame_done
  );

  modport slave (
    input  start, stop, mode, seg_len,
    output en, busy, seg_idx, frame_done
  );

endinterface

// File: rtl/pulse_pattern_gen_seg_timer.sv
// Segment timer: up-counter with clear and a terminal flag at length-1.
// A zero length behaves as a one-cycle segment so the counter never wraps.
module seg_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_term
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last = (i_len == '0) ? '0 : i_len - CNT_W'(1);
  assign o_term = (r_count == w_last);

  // Count cycles within the current segment; cleared on segment change or idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_pattern_gen.sv
// Programmable on/off enable pattern generator with shadowed segment lengths,
// continuous/one-shot frames, immediate stop and frame/segment status.
module pulse_pattern_gen
  import pulse_pattern_pkg::*;
#(
  parameter int   CNT_W     = DEF_CNT_W,
  parameter int   NUM_SEG   = DEF_NUM_SEG,
  parameter int   SEG_IDX_W = $clog2(NUM_SEG),
  parameter logic ON_LEVEL  = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  pulse_pattern_gen_if.slave bus
);

  state_t               r_state;
  logic                 r_mode;
  logic [CNT_W-1:0]     r_shadow [NUM_SEG];
  logic                 r_en;
  logic                 r_busy;
  logic [SEG_IDX_W-1:0] r_seg_idx;
  logic                 r_frame_done;

  logic [CNT_W-1:0]     w_cur_len;
  logic                 w_term;
  logic                 w_clr;
  logic                 w_last_seg;
  logic [SEG_IDX_W-1:0] w_next_idx;

  assign w_cur_len  = r_shadow[r_seg_idx];
  assign w_last_seg = (r_seg_idx == SEG_IDX_W'(NUM_SEG - 1));
  assign w_next_idx = r_seg_idx + SEG_IDX_W'(1);
  assign w_clr      = (r_state != RUN) || bus.stop || w_term;

  seg_timer #(.CNT_W(CNT_W)) u_seg_timer (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_clr),
    .i_len  (w_cur_len),
    .o_term (w_term)
  );

  // Frame FSM: shadow load, segment stepping and registered outputs.
  // stop is tested ahead of the terminal flag so an abort on the frame-end
  // cycle suppresses frame_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_mode       <= 1'b0;
      r_en         <= ~ON_LEVEL;
      r_busy       <= 1'b0;
      r_seg_idx    <= '0;
      r_frame_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            for (int unsigned i = 0; i < NUM_SEG; i++) begin
              r_shadow[i] <= bus.seg_len[i*CNT_W +: CNT_W];
            end
            r_mode    <= bus.mode;
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_seg_idx <= '0;
            r_en      <= ON_LEVEL;
          end
        end
        RUN: begin
          if (bus.stop) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_seg_idx <= '0;
            r_en      <= ~ON_LEVEL;
          end else if (w_term) begin
            if (w_last_seg) begin
              r_frame_done <= 1'b1;
              r_seg_idx    <= '0;
              if (!r_mode) begin
                for (int unsigned i = 0; i < NUM_SEG; i++) begin
                  r_shadow[i] <= bus.seg_len[i*CNT_W +: CNT_W];
                end
                r_en <= ON_LEVEL;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_en    <= ~ON_LEVEL;
              end
            end else begin
              r_seg_idx <= w_next_idx;
              r_en      <= seg_level(w_next_idx[0], ON_LEVEL);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.en         = r_en;
  assign bus.busy       = r_busy;
  assign bus.seg_idx    = r_seg_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_pulse_pattern_gen.sv
// Bench for pulse_pattern_gen: per-cycle expected outputs are queued when a
// scenario is driven and popped/compared on each falling edge.
module tb_pulse_pattern_gen;

  localparam int CNT_W   = 32;
  localparam int NUM_SEG = 4;

  typedef int unsigned len_arr_t [4];

  typedef struct {
    logic       en;
    logic       busy;
    logic [1:0] idx;
    logic       fd;
    logic       drv_stop;
    logic       swap;
  } exp_t;

  typedef struct {
    len_arr_t lens;
    logic     mode;
    int       nframes;
    string    name;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;
  exp_t q[$];
  vec_t vecs[6];
  logic [NUM_SEG*CNT_W-1:0] alt_len;
  string scen;

  pulse_pattern_gen_if #(.CNT_W(CNT_W), .NUM_SEG(NUM_SEG)) bus ();

  pulse_pattern_gen #(.CNT_W(CNT_W), .NUM_SEG(NUM_SEG), .ON_LEVEL(1'b1)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NUM_SEG*CNT_W-1:0] pack_len(input len_arr_t l);
    logic [NUM_SEG*CNT_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_SEG; i++) p[i*CNT_W +: CNT_W] = l[i];
    return p;
  endfunction

  function automatic exp_t mk(input logic en, input logic busy, input logic [1:0] idx, input logic fd);
    exp_t r;
    r.en = en; r.busy = busy; r.idx = idx; r.fd = fd; r.drv_stop = 1'b0; r.swap = 1'b0;
    return r;
  endfunction

  // Expected cycles of one frame (up to limit cycles); frame_done is seen on
  // the first cycle when the previous frame just completed.
  task automatic push_frame(input len_arr_t lens, input logic fd_first, input int limit);
    int n;
    int unsigned len;
    n = 0;
    for (int i = 0; i < NUM_SEG; i++) begin
      len = (lens[i] == 0) ? 1 : lens[i];
      for (int unsigned c = 0; c < len; c++) begin
        if (n < limit) q.push_back(mk(~i[0], 1'b1, i[1:0], (n == 0) ? fd_first : 1'b0));
        n++;
      end
    end
  endtask

  task automatic run_queue();
    exp_t r;
    int cyc;
    cyc = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      r = q.pop_front();
      chk($sformatf("%s c%0d en", scen, cyc), {31'd0, bus.en}, {31'd0, r.en});
      chk($sformatf("%s c%0d busy", scen, cyc), {31'd0, bus.busy}, {31'd0, r.busy});
      chk($sformatf("%s c%0d seg_idx", scen, cyc), {30'd0, bus.seg_idx}, {30'd0, r.idx});
      chk($sformatf("%s c%0d frame_done", scen, cyc), {31'd0, bus.frame_done}, {31'd0, r.fd});
      bus.start = 1'b0;
      bus.stop  = r.drv_stop;
      if (r.swap) bus.seg_len = alt_len;
      cyc++;
    end
  endtask

  task automatic do_start(input len_arr_t lens, input logic mode);
    bus.seg_len = pack_len(lens);
    bus.mode    = mode;
    bus.start   = 1'b1;
    bus.stop    = 1'b0;
  endtask

  initial begin
    len_arr_t l_base;
    len_arr_t l_two;
    n_checks = 0;
    n_fail   = 0;
    resetn = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.seg_len = '0;
    l_base = '{3, 5, 3, 7};
    l_two  = '{2, 2, 2, 2};
    alt_len = pack_len(l_two);

    vecs[0] = '{lens: '{3, 5, 3, 7}, mode: 1'b0, nframes: 2, name: "cont_3537"};
    vecs[1] = '{lens: '{3, 5, 3, 7}, mode: 1'b1, nframes: 1, name: "oneshot_3537"};
    vecs[2] = '{lens: '{3, 5, 3, 7}, mode: 1'b1, nframes: 1, name: "oneshot_rerun"};
    vecs[3] = '{lens: '{0, 4, 0, 4}, mode: 1'b0, nframes: 2, name: "zero_len"};
    vecs[4] = '{lens: '{1, 1, 1, 1}, mode: 1'b0, nframes: 3, name: "unit_len"};
    vecs[5] = '{lens: '{2, 0, 0, 1}, mode: 1'b1, nframes: 1, name: "oneshot_mixed"};

    #12;
    chk("reset en", {31'd0, bus.en}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset seg_idx", {30'd0, bus.seg_idx}, 32'd0);
    chk("reset frame_done", {31'd0, bus.frame_done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    scen = "post_reset_idle";
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    run_queue();

    foreach (vecs[v]) begin
      scen = vecs[v].name;
      do_start(vecs[v].lens, vecs[v].mode);
      for (int f = 0; f < vecs[v].nframes; f++) push_frame(vecs[v].lens, (f != 0), 1000);
      if (vecs[v].mode) begin
        q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1));
      end else begin
        q[$].drv_stop = 1'b1;
      end
      q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
      run_queue();
    end

    // Mid-frame reprogramming applies only at the next frame reload.
    scen = "shadowing";
    do_start(l_base, 1'b0);
    push_frame(l_base, 1'b0, 1000);
    q[3].swap = 1'b1;
    push_frame(l_two, 1'b1, 1000);
    q[$].drv_stop = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    run_queue();

    // Abort mid-frame: idle next cycle, no frame_done.
    scen = "stop_mid";
    do_start(l_base, 1'b0);
    push_frame(l_base, 1'b0, 6);
    q[$].drv_stop = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    run_queue();

    // start and stop together from idle: stays idle.
    scen = "start_stop_idle";
    do_start(l_base, 1'b0);
    bus.stop = 1'b1;
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    run_queue();

    // Async reset between edges mid-segment.
    scen = "pre_async_reset";
    do_start(l_base, 1'b0);
    push_frame(l_base, 1'b0, 5);
    run_queue();
    #2 resetn = 1'b0;
    #1;
    chk("async_reset en", {31'd0, bus.en}, 32'd0);
    chk("async_reset busy", {31'd0, bus.busy}, 32'd0);
    chk("async_reset seg_idx", {30'd0, bus.seg_idx}, 32'd0);
    chk("async_reset frame_done", {31'd0, bus.frame_done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    scen = "after_release";
    for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    run_queue();

    scen = "restart_after_reset";
    do_start(l_two, 1'b1);
    push_frame(l_two, 1'b0, 1000);
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1));
    q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0));
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
